// File: rtl/xosera_bus_host.sv
// ------------------------------------------------------------------------
// xosera_bus_host : 16-bit request to Xosera 8-bit register bus initiator
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module xosera_bus_host #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [1:0]  req_byte_en_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_intr_i,
  output logic        intr_o
);

  generate
    if (SETUP_CYC < 1 || SETUP_CYC > 65536) begin : g_bad_setup
      $fatal(1, "xosera_bus_host: SETUP_CYC must be in 1..65536");
    end
    if (STROBE_CYC < 2 || STROBE_CYC > 65536) begin : g_bad_strobe
      $fatal(1, "xosera_bus_host: STROBE_CYC must be in 2..65536");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 65536) begin : g_bad_hold
      $fatal(1, "xosera_bus_host: HOLD_CYC must be in 1..65536");
    end
  endgenerate

  localparam logic [15:0] c_setup_load  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] c_strobe_load = 16'(STROBE_CYC - 1);
  localparam logic [15:0] c_hold_load   = 16'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        wr_q;
  logic        word_q;
  logic [7:0]  wdata_lo_q;
  logic [15:0] rdata_q;

  logic        ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic        cs_n_q;
  logic        rd_nwr_q;
  logic        bytesel_q;
  logic [3:0]  reg_num_q;
  logic [7:0]  data_q;
  logic        oe_q;

  logic        sync1_q;
  logic        sync2_q;
  logic        prev_q;
  logic        intr_q;

  logic        accept_d;
  logic        first_bs_d;
  logic [7:0]  first_lane_d;
  logic        cnt_zero_d;
  logic [15:0] cnt_dec_d;

  assign accept_d     = req_valid_i & ready_q;
  // Even byte leads whenever it is enabled.
  assign first_bs_d   = ~req_byte_en_i[1];
  assign first_lane_d = first_bs_d ? req_data_i[7:0] : req_data_i[15:8];
  assign cnt_zero_d   = (cnt_q == 16'd0);
  assign cnt_dec_d    = cnt_q - 16'd1;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      wr_q        <= 1'b0;
      word_q      <= 1'b0;
      wdata_lo_q  <= 8'd0;
      rdata_q     <= 16'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
      cs_n_q      <= 1'b1;
      rd_nwr_q    <= 1'b1;
      bytesel_q   <= 1'b0;
      reg_num_q   <= 4'd0;
      data_q      <= 8'd0;
      oe_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            ready_q    <= 1'b0;
            wr_q       <= req_wr_i;
            word_q     <= &req_byte_en_i;
            wdata_lo_q <= req_data_i[7:0];
            rdata_q    <= 16'd0;
            reg_num_q  <= req_reg_num_i;
            if (req_byte_en_i == 2'b00) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 16'd0;
              rd_nwr_q    <= 1'b1;
              oe_q        <= 1'b0;
            end else begin
              state_q   <= ST_SETUP;
              cnt_q     <= c_setup_load;
              cs_n_q    <= 1'b1;
              rd_nwr_q  <= ~req_wr_i;
              oe_q      <= req_wr_i;
              bytesel_q <= first_bs_d;
              data_q    <= first_lane_d;
            end
          end
        end

        ST_SETUP: begin
          if (cnt_zero_d) begin
            state_q <= ST_STROBE;
            cnt_q   <= c_strobe_load;
            cs_n_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end

        ST_STROBE: begin
          if (cnt_zero_d) begin
            state_q <= ST_HOLD;
            cnt_q   <= c_hold_load;
            cs_n_q  <= 1'b1;
            // Target data-out is registered, so it is only trusted on the final strobe cycle.
            if (!wr_q) begin
              if (bytesel_q) begin
                rdata_q[7:0] <= bus_data_i;
              end else begin
                rdata_q[15:8] <= bus_data_i;
              end
            end
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end

        ST_HOLD: begin
          if (cnt_zero_d) begin
            if (word_q && !bytesel_q) begin
              state_q   <= ST_SETUP;
              cnt_q     <= c_setup_load;
              bytesel_q <= 1'b1;
              data_q    <= wdata_lo_q;
            end else begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= wr_q ? 16'd0 : rdata_q;
              rd_nwr_q    <= 1'b1;
              oe_q        <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Interrupt path runs on its own; the FSM never gates it.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      sync1_q <= bus_intr_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      intr_q  <= sync2_q & ~prev_q;
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign bus_cs_n_o    = cs_n_q;
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_bytesel_o = bytesel_q;
  assign bus_reg_num_o = reg_num_q;
  assign bus_data_o    = data_q;
  assign bus_data_oe_o = oe_q;
  assign intr_o        = intr_q;

endmodule

`default_nettype wire

// File: tb/tb_xosera_bus_host.sv
// ------------------------------------------------------------------------
// tb_xosera_bus_host : self-checking bench for xosera_bus_host
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_xosera_bus_host;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [3:0]  req_reg_num_i;
  logic [1:0]  req_byte_en_i;
  logic [15:0] req_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic        bus_bytesel_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic [7:0]  bus_data_i;
  logic        bus_intr_i;
  logic        intr_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;
  logic [7:0]  tgt_even;
  logic [7:0]  tgt_odd;

  logic        tr_cs  [0:31];
  logic        tr_oe  [0:31];
  logic        tr_rd  [0:31];
  logic        tr_bs  [0:31];
  logic        tr_rv  [0:31];
  logic        tr_rdy [0:31];
  logic [7:0]  tr_dat [0:31];
  logic [3:0]  tr_reg [0:31];

  xosera_bus_host #(.SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1)) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_wr_i      (req_wr_i),
    .req_reg_num_i (req_reg_num_i),
    .req_byte_en_i (req_byte_en_i),
    .req_data_i    (req_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .bus_cs_n_o    (bus_cs_n_o),
    .bus_rd_nwr_o  (bus_rd_nwr_o),
    .bus_bytesel_o (bus_bytesel_o),
    .bus_reg_num_o (bus_reg_num_o),
    .bus_data_o    (bus_data_o),
    .bus_data_oe_o (bus_data_oe_o),
    .bus_data_i    (bus_data_i),
    .bus_intr_i    (bus_intr_i),
    .intr_o        (intr_o)
  );

  always #5 clk = ~clk;

  // Target model: read data registered one cycle after cs_n is seen low.
  always @(posedge clk) begin
    if (!bus_cs_n_o) bus_data_i <= bus_bytesel_o ? tgt_odd : tgt_even;
    else             bus_data_i <= 8'hFF;
  end

  // Scoreboard: every response strobe pops the oldest expected read data.
  always @(negedge clk) begin
    if (reset_n_i === 1'b1 && rsp_valid_o === 1'b1) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_rsp: got rsp_data=%h, required no response", rsp_data_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rsp_data_o !== sb_exp)
          $display("FAIL sb_rsp_data: got %h, required %h", rsp_data_o, sb_exp);
        else
          pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
    $fatal(1, "watchdog");
  end

  // Presents a request in cycle 0, scrambles the inputs afterwards, records cycles 1..n.
  task automatic issue(input logic wr, input logic [3:0] rn, input logic [1:0] be,
                       input logic [15:0] d, input int n, output logic rdy0);
    @(posedge clk); #1;
    rdy0          = req_ready_o;
    req_valid_i   = 1'b1;
    req_wr_i      = wr;
    req_reg_num_i = rn;
    req_byte_en_i = be;
    req_data_i    = d;
    @(posedge clk); #1;
    req_valid_i   = 1'b0;
    req_wr_i      = ~wr;
    req_reg_num_i = ~rn;
    req_byte_en_i = ~be;
    req_data_i    = 16'($urandom);
    for (int c = 1; c <= n; c++) begin
      tr_cs[c]  = bus_cs_n_o;
      tr_oe[c]  = bus_data_oe_o;
      tr_rd[c]  = bus_rd_nwr_o;
      tr_bs[c]  = bus_bytesel_o;
      tr_rv[c]  = rsp_valid_o;
      tr_rdy[c] = req_ready_o;
      tr_dat[c] = bus_data_o;
      tr_reg[c] = bus_reg_num_o;
      if (c < n) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if ({req_ready_o, rsp_valid_o, rsp_data_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o,
         bus_reg_num_o, bus_data_o, bus_data_oe_o, intr_o} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b1,
         1'b0, 4'h0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_values: got rdy=%b rv=%b rd=%h cs=%b rnw=%b bs=%b reg=%h dat=%h oe=%b intr=%b",
               req_ready_o, rsp_valid_o, rsp_data_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o,
               bus_reg_num_o, bus_data_o, bus_data_oe_o, intr_o);
    else pass_cnt++;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    check_cnt++;
    if (req_ready_o !== 1'b1 || bus_cs_n_o !== 1'b1)
      $display("FAIL reset_idle: got rdy=%b cs_n=%b, required 1 1", req_ready_o, bus_cs_n_o);
    else pass_cnt++;
  endtask

  task automatic test_word_write();
    logic rdy0, e_cs, e_oe, e_rd, e_rv;
    exp_q.push_back(16'h0000);
    issue(1'b1, 4'h3, 2'b11, 16'hA55A, 13, rdy0);
    check_cnt++;
    if (rdy0 !== 1'b1) $display("FAIL ww_ready0: got %b, required 1", rdy0); else pass_cnt++;
    for (int c = 1; c <= 13; c++) begin
      e_cs = !((c >= 2 && c <= 4) || (c >= 7 && c <= 9));
      e_oe = (c <= 10);
      e_rd = (c > 10);
      e_rv = (c == 11);
      check_cnt++;
      if ({tr_cs[c], tr_oe[c], tr_rd[c], tr_rv[c], tr_rdy[c]} !== {e_cs, e_oe, e_rd, e_rv, 1'(c >= 12)})
        $display("FAIL ww_ctrl cyc%0d: got cs/oe/rnw/rv/rdy=%b%b%b%b%b, required %b%b%b%b%b", c,
                 tr_cs[c], tr_oe[c], tr_rd[c], tr_rv[c], tr_rdy[c], e_cs, e_oe, e_rd, e_rv, 1'(c >= 12));
      else pass_cnt++;
      if (!e_cs) begin
        check_cnt++;
        if (tr_bs[c] !== 1'(c >= 7) || tr_dat[c] !== ((c >= 7) ? 8'h5A : 8'hA5) || tr_reg[c] !== 4'h3)
          $display("FAIL ww_lane cyc%0d: got bs=%b data=%h reg=%h, required bs=%b data=%h reg=3", c,
                   tr_bs[c], tr_dat[c], tr_reg[c], 1'(c >= 7), (c >= 7) ? 8'h5A : 8'hA5);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_word_read();
    logic rdy0, e_cs;
    tgt_even = 8'h12;
    tgt_odd  = 8'h34;
    exp_q.push_back(16'h1234);
    issue(1'b0, 4'hC, 2'b11, 16'hFFFF, 13, rdy0);
    for (int c = 1; c <= 13; c++) begin
      e_cs = !((c >= 2 && c <= 4) || (c >= 7 && c <= 9));
      check_cnt++;
      if ({tr_cs[c], tr_oe[c], tr_rd[c], tr_rv[c]} !== {e_cs, 1'b0, 1'b1, 1'(c == 11)})
        $display("FAIL wr_ctrl cyc%0d: got cs/oe/rnw/rv=%b%b%b%b, required %b01%b", c,
                 tr_cs[c], tr_oe[c], tr_rd[c], tr_rv[c], e_cs, 1'(c == 11));
      else pass_cnt++;
    end
  endtask

  task automatic test_odd_read();
    logic rdy0;
    tgt_even = 8'h99;
    tgt_odd  = 8'hEF;
    exp_q.push_back(16'h00EF);
    issue(1'b0, 4'h2, 2'b01, 16'h0000, 8, rdy0);
    for (int c = 1; c <= 8; c++) begin
      check_cnt++;
      if (tr_cs[c] !== !(c >= 2 && c <= 4) || tr_rv[c] !== 1'(c == 6) ||
          (c <= 5 && tr_bs[c] !== 1'b1))
        $display("FAIL odd_rd cyc%0d: got cs=%b rv=%b bs=%b, required cs=%b rv=%b bs=1", c,
                 tr_cs[c], tr_rv[c], tr_bs[c], !(c >= 2 && c <= 4), 1'(c == 6));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic rdy0;
    exp_q.push_back(16'h0000);
    issue(1'b0, 4'h1, 2'b00, 16'hFFFF, 1, rdy0);
    check_cnt++;
    if (rdy0 !== 1'b1 || tr_cs[1] !== 1'b1 || tr_rv[1] !== 1'b1 || tr_rdy[1] !== 1'b0)
      $display("FAIL be0: got rdy0=%b cs=%b rv=%b rdy=%b, required 1 1 1 0",
               rdy0, tr_cs[1], tr_rv[1], tr_rdy[1]);
    else pass_cnt++;
    exp_q.push_back(16'h0000);
    issue(1'b1, 4'h7, 2'b11, 16'h0F0F, 12, rdy0);
    check_cnt++;
    if (rdy0 !== 1'b1) $display("FAIL b2b_ready: got %b, required 1", rdy0); else pass_cnt++;
    check_cnt++;
    if (tr_cs[1] !== 1'b1 || tr_cs[2] !== 1'b0 || tr_dat[2] !== 8'h0F || tr_rv[11] !== 1'b1 || tr_rv[10] !== 1'b0)
      $display("FAIL b2b_timing: got cs1=%b cs2=%b dat2=%h rv10=%b rv11=%b, required 1 0 0f 0 1",
               tr_cs[1], tr_cs[2], tr_dat[2], tr_rv[10], tr_rv[11]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    logic rdy0;
    exp_q.push_back(16'h0000);
    issue(1'b1, 4'h5, 2'b11, 16'hBEEF, 3, rdy0);
    check_cnt++;
    if (tr_cs[3] !== 1'b0 || tr_oe[3] !== 1'b1)
      $display("FAIL rst_pre: got cs=%b oe=%b, required 0 1", tr_cs[3], tr_oe[3]);
    else pass_cnt++;
    #2 reset_n_i = 1'b0;
    #1;
    check_cnt++;
    if (bus_cs_n_o !== 1'b1 || bus_data_oe_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
      $display("FAIL rst_async: got cs=%b oe=%b rv=%b rdy=%b, required 1 0 0 1",
               bus_cs_n_o, bus_data_oe_o, rsp_valid_o, req_ready_o);
    else pass_cnt++;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check_cnt++;
      if (rsp_valid_o !== 1'b0 || bus_cs_n_o !== 1'b1)
        $display("FAIL rst_quiet cyc%0d: got rv=%b cs=%b, required 0 1", c, rsp_valid_o, bus_cs_n_o);
      else pass_cnt++;
    end
    tgt_even = 8'hAB;
    tgt_odd  = 8'hCD;
    exp_q.push_back(16'hABCD);
    issue(1'b0, 4'h9, 2'b11, 16'h0000, 12, rdy0);
    check_cnt++;
    if (rdy0 !== 1'b1 || tr_rv[11] !== 1'b1 || tr_oe[5] !== 1'b0)
      $display("FAIL rst_after_rd: got rdy0=%b rv11=%b oe=%b, required 1 1 0", rdy0, tr_rv[11], tr_oe[5]);
    else pass_cnt++;
  endtask

  task automatic test_intr();
    logic tr_intr [0:31];
    @(posedge clk); #1;
    bus_intr_i = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 20) bus_intr_i = 1'b0;
      if (c == 22) bus_intr_i = 1'b1;
      tr_intr[c] = intr_o;
    end
    for (int c = 1; c <= 30; c++) begin
      check_cnt++;
      if (tr_intr[c] !== 1'(c == 3 || c == 25))
        $display("FAIL intr cyc%0d: got %b, required %b", c, tr_intr[c], 1'(c == 3 || c == 25));
      else pass_cnt++;
    end
    bus_intr_i = 1'b0;
  endtask

  initial begin
    reset_n_i     = 1'b0;
    req_valid_i   = 1'b0;
    req_wr_i      = 1'b0;
    req_reg_num_i = 4'h0;
    req_byte_en_i = 2'b00;
    req_data_i    = 16'h0000;
    bus_intr_i    = 1'b0;
    tgt_even      = 8'h00;
    tgt_odd       = 8'h00;

    test_reset();
    test_word_write();
    test_word_read();
    test_odd_read();
    test_back_to_back();
    test_reset_mid_write();
    test_intr();

    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending responses, required 0", exp_q.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

`default_nettype wire
